// File: rtl/aes_block_seq_if.sv
// Handshake bundle between the AES job sequencer and the key schedule,
// engine and source/sink streamers.
interface aes_block_seq_if;
  logic key_start;
  logic key_done;
  logic in_valid;
  logic in_ready;
  logic eng_start;
  logic eng_done;
  logic out_valid;
  logic out_ready;

  modport master (
    output key_start, in_ready, eng_start, out_valid,
    input  key_done, in_valid, eng_done, out_ready
  );
  modport slave (
    input  key_start, in_ready, eng_start, out_valid,
    output key_done, in_valid, eng_done, out_ready
  );
endinterface

// File: rtl/aes_block_seq.sv
// AES job sequencer: optional key expansion, then one block at a time through
// source -> engine -> sink, with progress, completion and protocol-error reporting.
module aes_block_seq #(
  parameter int CNT_WIDTH  = 16,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] nb_blocks_i,
  input  logic                 key_reload_i,
  aes_block_seq_if.master      bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] blk_cnt_o,
  output logic                 key_valid_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {IDLE, KEY_EXP, WAIT_IN, RUN, WAIT_OUT, DONE} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] nb_q, cnt_q, cnt_inc;
  logic                 key_start_q, eng_start_q, busy_q, done_q, key_valid_q, err_q;
  logic                 start_acc, need_key, in_hs, out_hs, key_ok, eng_ok, err_ev, last_blk;

  always_comb begin
    start_acc = (state_q == IDLE) && start_i;
    need_key  = (nb_blocks_i != '0) && (key_reload_i || !key_valid_q);
    in_hs     = (state_q == WAIT_IN) && bus.in_valid;
    out_hs    = (state_q == WAIT_OUT) && bus.out_ready;
    // a done landing in the same cycle as its own start pulse is not trusted
    key_ok    = (state_q == KEY_EXP) && bus.key_done && !key_start_q;
    eng_ok    = (state_q == RUN) && bus.eng_done && !eng_start_q;
    err_ev    = (bus.key_done && !key_ok) || (bus.eng_done && !eng_ok);
    cnt_inc   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    last_blk  = (cnt_inc == nb_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (nb_blocks_i == '0) state_d = DONE;
          else if (need_key)     state_d = KEY_EXP;
          else                   state_d = WAIT_IN;
        end
      end
      KEY_EXP:  if (key_ok) state_d = WAIT_IN;
      WAIT_IN:  if (bus.in_valid) state_d = RUN;
      RUN:      if (eng_ok) state_d = WAIT_OUT;
      WAIT_OUT: if (bus.out_ready) state_d = last_blk ? DONE : WAIT_IN;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      nb_q        <= '0;
      cnt_q       <= '0;
      key_start_q <= 1'b0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_start_q <= start_acc && need_key;
      eng_start_q <= in_hs;
      done_q      <= (state_q == DONE);
      if (start_acc) begin
        nb_q   <= nb_blocks_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (state_q == DONE) begin
        busy_q <= 1'b0;
      end
      if (out_hs) cnt_q <= cnt_inc;
      if (key_ok) key_valid_q <= 1'b1;
      if (ERR_STICKY) err_q <= (err_q && !start_acc) || err_ev;
      else            err_q <= err_ev;
    end
  end

  assign bus.key_start = key_start_q;
  assign bus.eng_start = eng_start_q;
  assign bus.in_ready  = (state_q == WAIT_IN);
  assign bus.out_valid = (state_q == WAIT_OUT);
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign blk_cnt_o     = cnt_q;
  assign key_valid_o   = key_valid_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_aes_block_seq.sv
// Bench for aes_block_seq: responders with per-block delays, and a job-level
// model predicting latency, pulse counts and handshake cycles by plain arithmetic.
module tb_aes_block_seq;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_i, clear_i, start_i, key_reload_i;
  logic [CW-1:0] nb_blocks_i;
  logic          busy_o, done_o, key_valid_o, err_o;
  logic [CW-1:0] blk_cnt_o;

  aes_block_seq_if bus ();

  aes_block_seq #(.CNT_WIDTH(CW), .ERR_STICKY(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .nb_blocks_i(nb_blocks_i), .key_reload_i(key_reload_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .blk_cnt_o(blk_cnt_o),
    .key_valid_o(key_valid_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  // per-block delays of the surrounding blocks
  int in_d[16], eng_l[16], out_d[16];
  int key_l = 4;
  bit slot_hit = 0, inj_eng = 0, force_out = 0;
  int in_base = 0, out_base = 0, eng_base = 0;
  bit model_kv = 0;

  // cumulative observations (jobs use deltas)
  int m_key = 0, m_eng = 0, m_inr = 0, m_outv = 0, m_busy = 0, m_done = 0, m_viol = 0;
  int in_hs = 0, out_hs = 0, in_idx = 0, out_idx = 0, eng_idx = 0;
  int key_tmr = 0, eng_tmr = 0, in_wait = 0, out_wait = 0;

  // observe first, then respond; one process keeps the ordering fixed
  always @(negedge clk) begin
    if (bus.key_start) m_key++;
    if (bus.in_ready)  m_inr++;
    if (bus.out_valid) m_outv++;
    if (busy_o)        m_busy++;
    if (done_o)        m_done++;
    if (bus.out_valid && (bus.in_ready || blk_cnt_o != CW'(out_idx - out_base))) m_viol++;
    if (rst_i || clear_i) begin key_tmr = 0; eng_tmr = 0; end

    bus.key_done = 1'b0;
    if (key_tmr > 0) begin key_tmr--; if (key_tmr == 0) bus.key_done = 1'b1; end
    if (bus.key_start) key_tmr = key_l;

    bus.eng_done = inj_eng;
    if (eng_tmr > 0) begin eng_tmr--; if (eng_tmr == 0) bus.eng_done = 1'b1; end
    if (bus.eng_start) begin
      m_eng++;
      eng_tmr = eng_l[(eng_idx - eng_base) & 15];
      eng_idx++;
      if (slot_hit) bus.eng_done = 1'b1;
    end

    bus.in_valid = 1'b0;
    if (bus.in_ready) begin
      if (in_wait >= in_d[(in_idx - in_base) & 15]) begin
        bus.in_valid = 1'b1; in_hs++; in_idx++; in_wait = 0;
      end else in_wait++;
    end else in_wait = 0;

    bus.out_ready = force_out;
    if (bus.out_valid && !force_out) begin
      if (out_wait >= out_d[(out_idx - out_base) & 15]) begin
        bus.out_ready = 1'b1; out_hs++; out_idx++; out_wait = 0;
      end else out_wait++;
    end else out_wait = 0;
  end

  task automatic cfg(input int kl, input int el, input bit rnd);
    key_l = rnd ? int'($urandom_range(1, 5)) : kl;
    for (int i = 0; i < 16; i++) begin
      in_d[i]  = rnd ? int'($urandom_range(0, 3)) : 0;
      out_d[i] = rnd ? int'($urandom_range(0, 3)) : 0;
      eng_l[i] = rnd ? int'($urandom_range(1, 5)) : el;
    end
  endtask

  task automatic rebase();
    in_base = in_idx; out_base = out_idx; eng_base = eng_idx;
  endtask

  // one job end-to-end, judged against the arithmetic job model
  task automatic run_job(input int nb, input bit rl, input bit exp_err, input int spur_at);
    int s, lat_exp, key_dur, inr_exp, outv_exp, first_inr, done_c;
    int k0, e0, i0, o0, r0, v0, b0, d0, w0;
    int act[16], exq[16];
    string nm[16];
    bit need, got, busy_dn;
    need     = (nb != 0) && (rl || !model_kv);
    key_dur  = need ? key_l + 1 : 0;
    lat_exp  = 2 + key_dur;
    inr_exp  = 0;
    outv_exp = 0;
    for (int i = 0; i < nb; i++) begin
      lat_exp  += in_d[i] + eng_l[i] + out_d[i] + 3;
      inr_exp  += in_d[i] + 1;
      outv_exp += out_d[i] + 1;
    end
    @(posedge clk); #2;
    rebase();
    k0 = m_key; e0 = m_eng; i0 = in_hs; o0 = out_hs; r0 = m_inr;
    v0 = m_outv; b0 = m_busy; d0 = m_done; w0 = m_viol;
    @(negedge clk);
    nb_blocks_i = CW'(nb); key_reload_i = rl; start_i = 1'b1; s = cyc;
    got = 0; first_inr = -1; done_c = -1; busy_dn = 1'b1;
    for (int c = 0; c < 600 && !got; c++) begin
      @(negedge clk);
      start_i = (c == spur_at);
      if (c == spur_at) begin nb_blocks_i = CW'(nb + 5); key_reload_i = 1'b1; end
      else begin nb_blocks_i = CW'($urandom); key_reload_i = 1'($urandom); end
      if (bus.in_ready && first_inr < 0) first_inr = cyc;
      if (done_o) begin got = 1; done_c = cyc; busy_dn = busy_o; end
    end
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    if (need) model_kv = 1'b1;
    nm = '{"job_done_seen", "job_latency", "key_start_pulses", "eng_start_pulses",
           "in_handshakes", "out_handshakes", "in_ready_cycles", "out_valid_cycles",
           "busy_cycles", "busy_at_done", "done_pulses", "blk_cnt_final",
           "key_valid", "err_flag", "first_in_ready_cycle", "stall_violations"};
    act[0]  = int'(got);               exq[0]  = 1;
    act[1]  = done_c - s;              exq[1]  = lat_exp;
    act[2]  = m_key - k0;              exq[2]  = int'(need);
    act[3]  = m_eng - e0;              exq[3]  = nb;
    act[4]  = in_hs - i0;              exq[4]  = nb;
    act[5]  = out_hs - o0;             exq[5]  = nb;
    act[6]  = m_inr - r0;              exq[6]  = inr_exp;
    act[7]  = m_outv - v0;             exq[7]  = outv_exp;
    act[8]  = m_busy - b0;             exq[8]  = lat_exp - 1;
    act[9]  = int'(busy_dn);           exq[9]  = 0;
    act[10] = m_done - d0;             exq[10] = 1;
    act[11] = int'(blk_cnt_o);         exq[11] = nb;
    act[12] = int'(key_valid_o);       exq[12] = int'(model_kv);
    act[13] = int'(err_o);             exq[13] = int'(exp_err);
    act[14] = (nb == 0) ? first_inr : first_inr - s;
    exq[14] = (nb == 0) ? -1 : 1 + key_dur;
    act[15] = m_viol - w0;             exq[15] = 0;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (act[i] !== exq[i]) begin
        n_err++;
        $display("FAIL %s (nb=%0d rl=%0d): got %0d expected %0d", nm[i], nb, rl, act[i], exq[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk); #2;
    n_chk++;
    if ({busy_o, done_o, key_valid_o, err_o, bus.key_start, bus.eng_start,
         bus.in_ready, bus.out_valid} !== 8'h00) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0", {busy_o, done_o, key_valid_o,
        err_o, bus.key_start, bus.eng_start, bus.in_ready, bus.out_valid});
    end
    n_chk++;
    if (blk_cnt_o !== '0) begin n_err++; $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt_o); end
    rst_i = 1'b0;
    repeat (2) @(posedge clk); #2;
    n_chk++;
    if ({busy_o, bus.in_ready, bus.out_valid, err_o} !== 4'h0) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected 0", {busy_o, bus.in_ready, bus.out_valid, err_o});
    end
    model_kv = 1'b0;
  endtask

  task automatic test_key_job();
    cfg(4, 10, 0);
    run_job(3, 1'b1, 1'b0, -1);
  endtask

  task automatic test_zero_blocks();
    cfg(4, 2, 0);
    run_job(0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_out_stall();
    cfg(4, 2, 0);
    out_d[0] = 7;
    run_job(2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    cfg(4, 2, 0);
    run_job(2, 1'b0, 1'b0, 3);
    run_job(1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 8; j++) begin
      cfg(0, 0, 1);
      run_job(int'($urandom_range(0, 5)), 1'($urandom), 1'b0, $urandom_range(0, 1) ? 2 : -1);
    end
  endtask

  task automatic test_reset_midjob();
    bit found = 0;
    cfg(4, 3, 0);
    eng_l[2] = 40;
    @(posedge clk); #2;
    rebase();
    @(negedge clk); nb_blocks_i = CW'(4); key_reload_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      found = (blk_cnt_o == CW'(2)) && busy_o && !bus.in_ready && !bus.out_valid;
    end
    n_chk++;
    if (!found) begin n_err++; $display("FAIL midjob_reach_run: got 0 expected 1"); end
    @(posedge clk); #2; rst_i = 1'b1;
    repeat (3) @(posedge clk); #2;
    n_chk++;
    if ({busy_o, done_o, key_valid_o, err_o, bus.key_start, bus.eng_start,
         bus.in_ready, bus.out_valid} !== 8'h00 || blk_cnt_o !== '0) begin
      n_err++; $display("FAIL midjob_reset_outputs: got %b cnt %0d expected 0", {busy_o, done_o,
        key_valid_o, err_o, bus.key_start, bus.eng_start, bus.in_ready, bus.out_valid}, blk_cnt_o);
    end
    rst_i = 1'b0;
    model_kv = 1'b0;
    cfg(4, 2, 0);
    run_job(1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_err_clear();
    bit found;
    int d0;
    cfg(4, 2, 0);
    // stray engine done while idle, then check stickiness and clear-on-start
    @(posedge clk); #2; inj_eng = 1'b1;
    @(posedge clk); #2; inj_eng = 1'b0;
    n_chk++;
    if (err_o !== 1'b1) begin n_err++; $display("FAIL err_idle_eng_done: got %b expected 1", err_o); end
    repeat (3) @(posedge clk); #2;
    n_chk++;
    if (err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", err_o); end
    run_job(1, 1'b0, 1'b0, -1);
    // engine done in the same cycle as its start pulse
    slot_hit = 1'b1;
    run_job(1, 1'b0, 1'b1, -1);
    slot_hit = 1'b0;
    // stray done during WAIT_IN, then clear racing the out handshake
    cfg(4, 2, 0);
    in_d[0] = 3; out_d[0] = 1000;
    @(posedge clk); #2;
    rebase();
    @(negedge clk); nb_blocks_i = CW'(2); key_reload_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (c > 0) @(negedge clk);
      found = bus.in_ready;
    end
    @(posedge clk); #2; inj_eng = 1'b1;
    @(posedge clk); #2; inj_eng = 1'b0;
    n_chk++;
    if ({err_o, bus.in_ready} !== 2'b11) begin
      n_err++; $display("FAIL err_wait_in_eng_done: got %b expected 11", {err_o, bus.in_ready});
    end
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      found = bus.out_valid;
    end
    n_chk++;
    if (!found || blk_cnt_o !== '0 || err_o !== 1'b1) begin
      n_err++; $display("FAIL err_wait_out_state: got valid %0d cnt %0d err %b expected 1 0 1", found, blk_cnt_o, err_o);
    end
    d0 = m_done;
    @(posedge clk); #2; force_out = 1'b1; clear_i = 1'b1;
    @(posedge clk); #2; force_out = 1'b0; clear_i = 1'b0;
    n_chk++;
    if ({busy_o, err_o, key_valid_o, bus.out_valid, bus.in_ready} !== 5'h0 || blk_cnt_o !== '0) begin
      n_err++; $display("FAIL clear_wins: got %b cnt %0d expected 0", {busy_o, err_o, key_valid_o,
        bus.out_valid, bus.in_ready}, blk_cnt_o);
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (m_done != d0) begin n_err++; $display("FAIL clear_no_done: got %0d expected 0", m_done - d0); end
    model_kv = 1'b0;
    cfg(4, 2, 0);
    run_job(2, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; key_reload_i = 1'b0; nb_blocks_i = '0;
    cfg(4, 2, 0);
    test_reset();
    test_key_job();
    test_zero_blocks();
    test_out_stall();
    test_back_to_back();
    test_random();
    test_reset_midjob();
    test_err_clear();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
